// File: rtl/memory_word_reader.sv
//============================================================================
// Module      : memory_word_reader
// Description : Read sequencer that fetches one word from a synchronous
//               memory and presents it on o_memory_word. This output feeds
//               the data_c input of the 3-channel bus multiplexer.
//               The block holds an address register that can be loaded or
//               incremented. It runs a request/ready handshake with memory
//               and marks each newly captured word with a one-cycle
//               o_word_valid pulse.
// Optional    : MEM_TIMEOUT_EN - when defined, a READ that sees no
//               i_mem_ready for TIMEOUT cycles is aborted. The abort is
//               flagged by a one-cycle o_rd_err pulse.
// Ports       : clk            rising-edge clock
//               rst_n          asynchronous active-low reset
//               i_addr_in      address to load
//               i_load_addr    load i_addr_in (IDLE only, beats incr)
//               i_incr_addr    address += 1, wrapping (IDLE only)
//               i_rd_req       start a read at the (updated) address
//               i_mem_ready    memory data valid this cycle
//               i_mem_rdata    memory read data
//               o_mem_addr     address register
//               o_mem_rd       read strobe, high in READ
//               o_memory_word  last captured word
//               o_word_valid   one-cycle pulse: o_memory_word updated
//               o_busy         high whenever not IDLE
//               o_rd_err       one-cycle pulse: read aborted by timeout
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module memory_word_reader #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE-1:0] i_addr_in,
    input  logic                 i_load_addr,
    input  logic                 i_incr_addr,
    input  logic                 i_rd_req,
    input  logic                 i_mem_ready,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic                 o_mem_rd,
    output logic [WORD_SIZE-1:0] o_memory_word,
    output logic                 o_word_valid,
    output logic                 o_busy,
    output logic                 o_rd_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_word;
    logic                   r_mem_rd;
    logic                   r_word_valid;
    logic                   r_busy;

`ifdef MEM_TIMEOUT_EN
    localparam int                   c_CNT_W    = $clog2(TIMEOUT + 1);
    // The counter holds 0 in the first READ cycle. Its value TIMEOUT-1
    // therefore marks the last READ cycle that is still allowed.
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_rd_err;
`endif

    // All outputs are registered. The strobes are written together with the
    // state, so each one tracks its state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_word       <= '0;
            r_mem_rd     <= 1'b0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt        <= '0;
            r_rd_err     <= 1'b0;
`endif
        end else begin
            r_word_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_rd_err     <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // The address updates on the same edge that launches a
                    // read, so a simultaneous load/incr applies to this read.
                    if (i_load_addr) begin
                        r_addr <= i_addr_in;
                    end else if (i_incr_addr) begin
                        r_addr <= r_addr + ADDR_SIZE'(1);
                    end
                    if (i_rd_req) begin
                        r_state  <= S_READ;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                S_READ: begin
                    // A ready in the final allowed cycle beats the timeout.
                    if (i_mem_ready) begin
                        r_state      <= S_DONE;
                        r_word       <= i_mem_rdata;
                        r_mem_rd     <= 1'b0;
                        r_word_valid <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == c_CNT_LAST) begin
                        r_state  <= S_IDLE;
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_rd_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_addr    = r_addr;
    assign o_mem_rd      = r_mem_rd;
    assign o_memory_word = r_word;
    assign o_word_valid  = r_word_valid;
    assign o_busy        = r_busy;
`ifdef MEM_TIMEOUT_EN
    assign o_rd_err      = r_rd_err;
`else
    assign o_rd_err      = 1'b0;
`endif

endmodule

`default_nettype wire
